// File: rtl/voice_allocator.sv
// Note-event scheduler that maps MIDI note-on/off events onto a fixed pool of voice slots.
// Allocation priority is retrigger same note, then lowest free slot, then steal the oldest slot.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned NOTE_WIDTH = 7,
  parameter int unsigned VEL_WIDTH  = 7
) (
  input  logic                             clock_50_000_000,
  input  logic                             reset,
  input  logic                             event_valid,
  output logic                             event_ready,
  input  logic                             event_on,
  input  logic [NOTE_WIDTH-1:0]            event_note,
  input  logic [VEL_WIDTH-1:0]             event_velocity,
  input  logic                             all_notes_off,
  output logic [NUM_VOICES-1:0]            voice_active,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity,
  output logic [NUM_VOICES-1:0]            voice_start,
  output logic [NUM_VOICES-1:0]            voice_release,
  output logic                             voice_stolen,
  output logic [$clog2(NUM_VOICES+1)-1:0]  active_count
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);
  localparam int unsigned CntW = $clog2(NUM_VOICES+1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam idx_t LastIdx = idx_t'(NUM_VOICES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StCommit, StAllOff} state_e;

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  logic   pending_q, pending_d;

  logic                  ev_on_q, ev_on_d;
  logic [NOTE_WIDTH-1:0] ev_note_q, ev_note_d;
  logic [VEL_WIDTH-1:0]  ev_vel_q, ev_vel_d;

  logic match_found_q, match_found_d;
  idx_t match_idx_q, match_idx_d;
  logic free_found_q, free_found_d;
  idx_t free_idx_q, free_idx_d;
  logic oldest_found_q, oldest_found_d;
  idx_t oldest_idx_q, oldest_idx_d;
  idx_t oldest_age_q, oldest_age_d;

  logic [NUM_VOICES-1:0]            active_q, active_d;
  logic [NUM_VOICES*NOTE_WIDTH-1:0] note_q, note_d;
  logic [NUM_VOICES*VEL_WIDTH-1:0]  vel_q, vel_d;
  idx_t                             age_q [NUM_VOICES];
  idx_t                             age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]            start_q, start_d;
  logic [NUM_VOICES-1:0]            release_q, release_d;
  logic                             stolen_q, stolen_d;
  cnt_t                             count_q, count_d;

  idx_t target;
  logic steal;

  assign event_ready = (state_q == StIdle) && !pending_q && !reset;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    ev_on_d        = ev_on_q;
    ev_note_d      = ev_note_q;
    ev_vel_d       = ev_vel_q;
    match_found_d  = match_found_q;
    match_idx_d    = match_idx_q;
    free_found_d   = free_found_q;
    free_idx_d     = free_idx_q;
    oldest_found_d = oldest_found_q;
    oldest_idx_d   = oldest_idx_q;
    oldest_age_d   = oldest_age_q;
    active_d       = active_q;
    note_d         = note_q;
    vel_d          = vel_q;
    age_d          = age_q;
    start_d        = '0;
    release_d      = '0;
    stolen_d       = 1'b0;
    target         = '0;
    steal          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q || all_notes_off) begin
          state_d = StAllOff;
        end else if (event_valid && event_ready) begin
          // Zero-velocity note-on is a note-off by MIDI convention.
          ev_on_d        = event_on && (event_velocity != '0);
          ev_note_d      = event_note;
          ev_vel_d       = event_velocity;
          idx_d          = '0;
          match_found_d  = 1'b0;
          free_found_d   = 1'b0;
          oldest_found_d = 1'b0;
          state_d        = StScan;
        end
      end

      StScan: begin
        if (all_notes_off) pending_d = 1'b1;
        if (active_q[idx_q] && !match_found_q &&
            (note_q[idx_q*NOTE_WIDTH +: NOTE_WIDTH] == ev_note_q)) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!active_q[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (active_q[idx_q] && (!oldest_found_q || (age_q[idx_q] > oldest_age_q))) begin
          oldest_found_d = 1'b1;
          oldest_idx_d   = idx_q;
          oldest_age_d   = age_q[idx_q];
        end
        if (idx_q == LastIdx) begin
          state_d = StCommit;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end

      StCommit: begin
        if (all_notes_off) pending_d = 1'b1;
        state_d = StIdle;
        if (ev_on_q) begin
          if (match_found_q) begin
            target = match_idx_q;
          end else if (free_found_q) begin
            target = free_idx_q;
          end else begin
            target = oldest_idx_q;
            steal  = 1'b1;
          end
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (idx_t'(i) == target) begin
              active_d[i]                           = 1'b1;
              note_d[i*NOTE_WIDTH +: NOTE_WIDTH]    = ev_note_q;
              vel_d[i*VEL_WIDTH +: VEL_WIDTH]       = ev_vel_q;
              start_d[i]                            = 1'b1;
              age_d[i]                              = '0;
            end else if (active_q[i] && (age_q[i] != LastIdx)) begin
              age_d[i] = age_q[i] + idx_t'(1);
            end
          end
          stolen_d = steal;
        end else if (match_found_q) begin
          active_d[match_idx_q]  = 1'b0;
          release_d[match_idx_q] = 1'b1;
          age_d[match_idx_q]     = '0;
        end
      end

      StAllOff: begin
        release_d = active_q;
        active_d  = '0;
        pending_d = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) age_d[i] = '0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase

    count_d = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (active_d[i]) count_d = count_d + cnt_t'(1);
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      ev_on_q        <= 1'b0;
      ev_note_q      <= '0;
      ev_vel_q       <= '0;
      match_found_q  <= 1'b0;
      match_idx_q    <= '0;
      free_found_q   <= 1'b0;
      free_idx_q     <= '0;
      oldest_found_q <= 1'b0;
      oldest_idx_q   <= '0;
      oldest_age_q   <= '0;
      active_q       <= '0;
      note_q         <= '0;
      vel_q          <= '0;
      age_q          <= '{default: '0};
      start_q        <= '0;
      release_q      <= '0;
      stolen_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      ev_on_q        <= ev_on_d;
      ev_note_q      <= ev_note_d;
      ev_vel_q       <= ev_vel_d;
      match_found_q  <= match_found_d;
      match_idx_q    <= match_idx_d;
      free_found_q   <= free_found_d;
      free_idx_q     <= free_idx_d;
      oldest_found_q <= oldest_found_d;
      oldest_idx_q   <= oldest_idx_d;
      oldest_age_q   <= oldest_age_d;
      active_q       <= active_d;
      note_q         <= note_d;
      vel_q          <= vel_d;
      age_q          <= age_d;
      start_q        <= start_d;
      release_q      <= release_d;
      stolen_q       <= stolen_d;
      count_q        <= count_d;
    end
  end

  assign voice_active   = active_q;
  assign voice_note     = note_q;
  assign voice_velocity = vel_q;
  assign voice_start    = start_q;
  assign voice_release  = release_q;
  assign voice_stolen   = stolen_q;
  assign active_count   = count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with four voices: allocation, retrigger, steal,
// note-off, all-notes-off deferral and reset abort.
module tb_voice_allocator;

  localparam int unsigned NV = 4;
  localparam int unsigned NW = 7;
  localparam int unsigned VW = 7;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            event_valid = 1'b0;
  logic            event_ready;
  logic            event_on = 1'b0;
  logic [NW-1:0]   event_note = '0;
  logic [VW-1:0]   event_velocity = '0;
  logic            all_notes_off = 1'b0;
  logic [NV-1:0]   voice_active;
  logic [NV*NW-1:0] voice_note;
  logic [NV*VW-1:0] voice_velocity;
  logic [NV-1:0]   voice_start;
  logic [NV-1:0]   voice_release;
  logic            voice_stolen;
  logic [2:0]      active_count;

  int checks = 0;
  int errors = 0;
  logic [NV-1:0] pre_start;
  logic [NV-1:0] pre_release;

  voice_allocator #(
    .NUM_VOICES(NV),
    .NOTE_WIDTH(NW),
    .VEL_WIDTH (VW)
  ) dut (
    .clock_50_000_000(clk),
    .reset           (reset),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_on        (event_on),
    .event_note      (event_note),
    .event_velocity  (event_velocity),
    .all_notes_off   (all_notes_off),
    .voice_active    (voice_active),
    .voice_note      (voice_note),
    .voice_velocity  (voice_velocity),
    .voice_start     (voice_start),
    .voice_release   (voice_release),
    .voice_stolen    (voice_stolen),
    .active_count    (active_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] vnote(input int i);
    return voice_note[i*NW +: NW];
  endfunction

  function automatic logic [VW-1:0] vvel(input int i);
    return voice_velocity[i*VW +: VW];
  endfunction

  // Returns at the falling edge of the first cycle in which the commit is visible.
  task automatic send(input bit on, input logic [NW-1:0] note, input logic [VW-1:0] vel,
                      input bit aoff);
    int waits = 0;
    @(negedge clk);
    while (!event_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("ready_before_event", event_ready, 1);
    event_valid    = 1'b1;
    event_on       = on;
    event_note     = note;
    event_velocity = vel;
    @(posedge clk);
    #1 event_valid = 1'b0;
    for (int k = 1; k <= NV; k++) begin
      @(posedge clk);
      #1 all_notes_off = aoff && (k == 1);
    end
    @(negedge clk);
    pre_start   = voice_start;
    pre_release = voice_release;
    @(posedge clk);
    @(negedge clk);
    check("no_early_pulse", {pre_start, pre_release}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", event_ready, 0);
    check("reset_outputs", {voice_active, voice_start, voice_release, voice_stolen,
                            active_count, voice_note, voice_velocity}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", event_ready, 1);

    // Three fresh notes into slots 0..2; 6-cycle transfer-to-visible latency.
    send(1, 7'd60, 7'd100, 0);
    check("n60_start", voice_start, 4'b0001);
    check("n60_note", vnote(0), 60);
    check("n60_vel", vvel(0), 100);
    check("n60_count", active_count, 1);
    send(1, 7'd64, 7'd90, 0);
    check("n64_start", voice_start, 4'b0010);
    check("n64_note", vnote(1), 64);
    send(1, 7'd67, 7'd80, 0);
    check("n67_start", voice_start, 4'b0100);
    check("n67_vel", vvel(2), 80);
    check("n67_active", voice_active, 4'b0111);
    check("n67_count", active_count, 3);
    @(negedge clk);
    check("start_one_cycle", voice_start, 0);

    // Retrigger of an already sounding note.
    send(1, 7'd64, 7'd20, 0);
    check("retrig_start", voice_start, 4'b0010);
    check("retrig_vel", vvel(1), 20);
    check("retrig_count", active_count, 3);
    check("retrig_stolen", voice_stolen, 0);

    send(1, 7'd72, 7'd70, 0);
    check("n72_start", voice_start, 4'b1000);
    check("n72_count", active_count, 4);

    // Pool full: slot 0 holds the oldest note and is stolen.
    send(1, 7'd76, 7'd60, 0);
    check("steal_flag", voice_stolen, 1);
    check("steal_start", voice_start, 4'b0001);
    check("steal_note", vnote(0), 76);
    check("steal_vel", vvel(0), 60);
    check("steal_release", voice_release, 0);
    check("steal_count", active_count, 4);
    @(negedge clk);
    check("stolen_one_cycle", voice_stolen, 0);

    send(0, 7'd67, 7'd0, 0);
    check("off67_release", voice_release, 4'b0100);
    check("off67_active", voice_active, 4'b1011);
    check("off67_count", active_count, 3);
    check("off67_start", voice_start, 0);
    check("off67_note_kept", vnote(2), 67);

    // Zero-velocity note-on releases.
    send(1, 7'd72, 7'd0, 0);
    check("v0_release", voice_release, 4'b1000);
    check("v0_active", voice_active, 4'b0011);
    check("v0_count", active_count, 2);

    send(0, 7'd50, 7'd0, 0);
    check("nomatch_pulses", {voice_start, voice_release, voice_stolen}, 0);
    check("nomatch_active", voice_active, 4'b0011);
    check("nomatch_count", active_count, 2);

    // all_notes_off during SCAN: event commits, then deferred all-off.
    send(1, 7'd67, 7'd80, 1);
    check("aoff_commit_start", voice_start, 4'b0100);
    check("aoff_commit_active", voice_active, 4'b0111);
    check("aoff_ready_pending", event_ready, 0);
    @(negedge clk);
    check("aoff_ready_alloff", event_ready, 0);
    check("aoff_no_release_yet", voice_release, 0);
    @(negedge clk);
    check("aoff_release", voice_release, 4'b0111);
    check("aoff_active", voice_active, 0);
    check("aoff_count", active_count, 0);
    check("aoff_ready_done", event_ready, 1);
    @(negedge clk);
    check("aoff_release_one_cycle", voice_release, 0);

    // Reset mid-SCAN aborts the pending note-on.
    event_valid    = 1'b1;
    event_on       = 1'b1;
    event_note     = 7'd60;
    event_velocity = 7'd100;
    @(posedge clk);
    #1 event_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_state", {voice_active, voice_start, active_count}, 0);
    check("abort_ready", event_ready, 1);
    repeat (NV + 2) @(negedge clk);
    check("abort_no_commit", {voice_active, voice_start, voice_release}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
